// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared widths and the output-buffer state encoding used by
//            adder_pipe and its combinational adder.
// Contents : OP_W   - operand width (6)
//            SUM_W  - sum width including carry out (7)
//            CNT_W  - delivery / carry counter width (16)
//            buf_state_e - EMPTY (0 entries), HALF (1), FULL (2)
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int OP_W  = 6;
    localparam int SUM_W = 7;
    localparam int CNT_W = 16;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Zero-extending add; the extra MSB carries the carry out so no sum
    // is ever truncated.
    function automatic logic [SUM_W-1:0] add_ext(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Purpose  : Purely combinational unsigned 6 + 6 -> 7 bit adder. Sits
//            between the operand inputs and the buffer write port of
//            adder_pipe.
// Ports    : a_i   [OP_W-1:0]  first operand
//            b_i   [OP_W-1:0]  second operand
//            sum_o [SUM_W-1:0] a_i + b_i, MSB is carry out
// Revision : 1.0 - initial release
// ============================================================================
module adder
    import adder_pkg::*;
(
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    output logic [SUM_W-1:0] sum_o
);

    assign sum_o = add_ext(a_i, b_i);

endmodule : adder
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Ready/valid wrapped adder. Each accepted operand pair is summed
//            combinationally and written into a two-entry output buffer;
//            sums leave in acceptance order with one cycle of latency when
//            the buffer is empty.
// Params   : DEPTH - output buffer entries (only 2 is legal)
// Ports    : clk       rising-edge clock
//            rst       asynchronous active-high reset
//            in_valid  operand pair present
//            in_ready  block accepts an operand pair (registered)
//            x, y      unsigned operands [OP_W-1:0]
//            out_valid sum available (registered)
//            out_ready consumer takes the sum
//            s         head sum [SUM_W-1:0], bit 6 is carry out, 0 when idle
//            txn_cnt   sums delivered              (ADDER_PIPE_CNT_EN only)
//            carry_cnt delivered sums with s[6]=1  (ADDER_PIPE_CNT_EN only)
// Config   : define ADDER_PIPE_CNT_EN to build the two delivery counters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe
    import adder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] s
`ifdef ADDER_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    buf_state_e              state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [SUM_W-1:0]        mem_q [DEPTH];

    logic [SUM_W-1:0]        w_sum;
    logic [SUM_W-1:0]        w_head;
    logic                    w_push;
    logic                    w_pop;

    // in_ready_q is low whenever the buffer is FULL, so a push can never
    // land on a stored entry; out_ready has no path into in_ready.
    assign w_push = in_valid  && in_ready_q;
    assign w_pop  = out_valid_q && out_ready;
    assign w_head = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Combinational adder between operands and buffer write port
    // ------------------------------------------------------------------
    adder u_adder (
        .a_i   (x),
        .b_i   (y),
        .sum_o (w_sum)
    );

    // ------------------------------------------------------------------
    // Occupancy FSM. in_ready and out_valid are registered alongside the
    // state so both are pure register outputs. in_ready is held low while
    // reset is asserted even though the state is EMPTY, and rises on the
    // first edge after reset releases.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_push) begin
                        state_q     <= HALF;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                HALF: begin
                    if (w_push && !w_pop) begin
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (!w_push && w_pop) begin
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q     <= HALF;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        state_q     <= HALF;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage and pointers. Clearing the entries on reset means a
    // reset mid-transfer leaves nothing that could later surface on s.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_sum;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional delivery counters; both wrap naturally at 16 bits.
    // ------------------------------------------------------------------
`ifdef ADDER_PIPE_CNT_EN
    logic [CNT_W-1:0] txn_cnt_q;
    logic [CNT_W-1:0] carry_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt_q   <= '0;
            carry_cnt_q <= '0;
        end else if (w_pop) begin
            txn_cnt_q <= txn_cnt_q + 1'b1;
            if (w_head[SUM_W-1]) begin
                carry_cnt_q <= carry_cnt_q + 1'b1;
            end
        end
    end

    assign txn_cnt   = txn_cnt_q;
    assign carry_cnt = carry_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = out_valid_q ? w_head : '0;

endmodule : adder_pipe
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Purpose  : Self-checking directed bench for adder_pipe, closing with an
//            exhaustive operand sweep under random back-pressure.
// Config   : counter checks are built only when ADDER_PIPE_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] x = '0;
    logic [5:0] y = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] s;
`ifdef ADDER_PIPE_CNT_EN
    logic [15:0] txn_cnt;
    logic [15:0] carry_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    adder_pipe #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
`ifdef ADDER_PIPE_CNT_EN
        ,
        .txn_cnt   (txn_cnt),
        .carry_cnt (carry_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges, released 1 time unit after an edge;
    // returns one edge later with in_ready expected high.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    int exp_q[$];
    int produced;
    int consumed;
    int cycles;
    int exp_v;

    initial begin
        // ---------------- Reset values ----------------
        #2;
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        tick();
        tick();
        check("rst_in_ready_clk", in_ready, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
`ifdef ADDER_PIPE_CNT_EN
        check("rst_txn", txn_cnt, 0);
        check("rst_carry", carry_cnt, 0);
`endif

        // ---------------- 63 + 63 ----------------
        x = 6'd63; y = 6'd63; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("max_out_valid", out_valid, 1);
        check("max_s", s, 7'b1111110);
        tick();
        check("max_drained", out_valid, 0);
        check("max_idle_s", s, 0);
`ifdef ADDER_PIPE_CNT_EN
        check("max_txn", txn_cnt, 1);
        check("max_carry", carry_cnt, 1);
`endif

        // ---------------- 0 + 0 and 32 + 32 ----------------
        x = 6'd0; y = 6'd0; in_valid = 1'b1;
        tick();
        x = 6'd32; y = 6'd32;
        check("zero_valid", out_valid, 1);
        check("zero_s", s, 0);
        tick();
        in_valid = 1'b0;
        check("c64_valid", out_valid, 1);
        check("c64_s", s, 64);
        tick();
        check("c64_drained", out_valid, 0);

        // ---------------- Back-pressure and order ----------------
        do_reset();
        x = 6'd1; y = 6'd2; in_valid = 1'b1;
        tick();
        check("bp_half_ready", in_ready, 1);
        x = 6'd3; y = 6'd4;
        tick();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_s", s, 3);
        x = 6'd5; y = 6'd6;
        tick();
        tick();
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_s", s, 3);
        out_ready = 1'b1;
        tick();
        check("bp_second_s", s, 7);
        check("bp_second_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_third_s", s, 11);
        tick();
        check("bp_drained", out_valid, 0);
`ifdef ADDER_PIPE_CNT_EN
        check("bp_txn", txn_cnt, 3);
        check("bp_carry", carry_cnt, 0);
`endif

        // ---------------- Steady HALF with push and pop ----------------
        do_reset();
        x = 6'd10; y = 6'd20; in_valid = 1'b1;
        tick();
        exp_v = 30;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = 6'(i + 1); y = 6'(i + 1);
            check("half_ready", in_ready, 1);
            check("half_s", s, exp_v);
            tick();
            exp_v = 2 * (i + 1);
        end
        in_valid = 1'b0;
        check("half_still", out_valid, 1);
        check("half_last_s", s, 20);
`ifdef ADDER_PIPE_CNT_EN
        check("half_txn", txn_cnt, 10);
`endif
        tick();
        check("half_drained", out_valid, 0);

        // ---------------- Async reset while FULL ----------------
        do_reset();
        x = 6'd40; y = 6'd41; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("arst_full", in_ready, 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_s", s, 0);
        check("arst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("arst_no_stale", out_valid, 0);
        check("arst_no_stale_s", s, 0);
`ifdef ADDER_PIPE_CNT_EN
        check("arst_txn", txn_cnt, 0);
`endif

        // ---------------- Exhaustive sweep ----------------
        do_reset();
        produced = 0;
        consumed = 0;
        cycles   = 0;
        while (consumed < 4096 && cycles < 40000) begin
            x = 6'(produced >> 6);
            y = 6'(produced & 63);
            in_valid  = (produced < 4096) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("exh_spurious", 1, 0);
                end else begin
                    check("exh_s", s, exp_q.pop_front());
                end
                consumed++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back((produced >> 6) + (produced & 63));
                produced++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        check("exh_consumed", consumed, 4096);
`ifdef ADDER_PIPE_CNT_EN
        check("exh_txn", txn_cnt, 4096);
        check("exh_carry", carry_cnt, 2016);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_adder_pipe
`default_nettype wire
